keypress_pcm_scheduler: RTL and testbench
=========================================

# keypress_pcm_scheduler

Controller between the PS/2 scancode FIFO and the PCM sample player in the keyboard-synth top level. It pops Set-2 scancodes, tracks F0 (break) and E0 (extended) prefixes, maps eight make codes to sample slots, and sequences the player with one-cycle stop/init pulses. It also suppresses typematic repeats and bounds the wait for the player to go idle.

## Interface
- SAMPLE_LOG2, 12, log2 of words per sample slot; slot base = idx << SAMPLE_LOG2
- ADDR_W, 15, width of pcm_addr; must be ≥ SAMPLE_LOG2+3
- STOP_ON_RELEASE, 1, 1 = break code of the playing key stops playback
- WAIT_TIMEOUT, 1000000, max cycles in WAIT before forcing progress (10 ms at 100 MHz)

- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  scancode FIFO empty (first-word-fall-through)
- fifo_data  in  8  FIFO head byte, valid while !fifo_empty
- fifo_rd  out  1  pop strobe, one cycle
- pcm_busy  in  1  player active; rises the cycle after pcm_init
- pcm_init  out  1  one-cycle start pulse
- pcm_stop  out  1  one-cycle abort pulse
- pcm_addr  out  ADDR_W  slot base, held stable from pcm_init until the next pcm_init
- play_count  out  16  number of pcm_init pulses issued, wraps 0xFFFF→0
- err_timeout  out  1  sticky; set on a WAIT timeout, cleared only by rst

## Operation
- Key map: 1C→0, 1B→1, 23→2, 2B→3, 34→4, 33→5, 3B→6, 42→7. All other codes are unmapped.
- Internal registers: brk, ext, held, held_idx[2:0], play_idx[2:0], go_start, wait_cnt.
- States: IDLE, DECODE, STOP, WAIT, START, ARM.
- IDLE: if !fifo_empty, assert fifo_rd, capture fifo_data into byte_q, go to DECODE.
- DECODE:
  - F0: set brk → IDLE.
  - E0: set ext → IDLE.
  - AA, FA, FE, 00, FF, or unmapped: clear brk and ext → IDLE.
  - ext set with a mapped code: treat as unmapped.
- Break of a mapped code (brk=1): clear brk.
  - If held and idx==held_idx, clear held.
  - If STOP_ON_RELEASE and pcm_busy and idx==play_idx: go_start←0 → STOP.
  - Otherwise → IDLE.
- Make of a mapped code:
  - held and idx==held_idx: typematic repeat, ignore → IDLE.
  - Otherwise: held←1, held_idx←idx, go_start←1. → STOP if pcm_busy, else → START.
- STOP: pcm_stop=1 for one cycle, wait_cnt←0 → WAIT.
- WAIT: wait_cnt increments each cycle.
  - Exit when !pcm_busy, or when wait_cnt==WAIT_TIMEOUT-1 (also set err_timeout).
  - Exit goes to START if go_start, else IDLE.
- START: pcm_init=1, pcm_addr←held_idx<<SAMPLE_LOG2, play_idx←held_idx, play_count+1 → ARM.
- ARM: one cycle, lets pcm_busy rise → IDLE.
- Only one byte is in flight; the FIFO is not popped outside IDLE, so it buffers bytes during STOP/WAIT.
- Reset:
  - state=IDLE; all flags, counters and pcm_addr = 0.
  - fifo_rd, pcm_init, pcm_stop, err_timeout = 0.
  - Reset mid-WAIT or mid-START abandons the operation and issues no pulse.

## Timing
- fifo_rd, pcm_init and pcm_stop decode from the registered state: glitch-free, exactly one cycle high.
- Make byte popped at cycle N with player idle: DECODE at N+1, pcm_init at N+2, next pop no earlier than N+4.
- Make byte with player busy: pcm_stop at N+2, WAIT from N+3, pcm_init one cycle after the first cycle pcm_busy is sampled low.
- Prefix bytes (F0, E0) cost 2 cycles each. A full break sequence (F0 xx) causes no pcm_init.
- pcm_stop and pcm_init are never asserted in the same cycle. There are always at least 2 cycles between stop and init.
- A timeout takes exactly WAIT_TIMEOUT cycles in WAIT.

## Test plan
- Idle player, FIFO holds 1C → fifo_rd once, pcm_init 2 cycles later, pcm_addr=0x0000, play_count=1.
- While 1C plays (pcm_busy=1), push 1B → pcm_stop pulse. Drop busy 5 cycles later → pcm_init next cycle, pcm_addr=0x1000, play_count=2.
- Push 1C, 1C, 1C (typematic), then F0 1C with STOP_ON_RELEASE=1 and busy held → exactly one pcm_init, then one pcm_stop; held clears.
- Push E0 1C, then 00, then 5A → no pcm_init, no pcm_stop; all three popped; brk/ext clear afterward.
- Keep pcm_busy stuck at 1, push 23 (WAIT_TIMEOUT=100 in bench) → pcm_stop, then err_timeout rises after 100 WAIT cycles, then pcm_init with pcm_addr=0x2000; err_timeout stays high until rst.
- Assert rst for 1 cycle during WAIT → next cycle all outputs 0, state IDLE. A subsequent 34 produces pcm_init with pcm_addr=0x4000 and play_count=1.

Source files
------------

// File: rtl/keypress_pcm_scheduler.sv
// Pops PS/2 Set-2 scancodes, tracks break/extended prefixes and sequences the PCM
// sample player with single-cycle stop/init pulses, typematic suppression and a bounded idle wait.
module keypress_pcm_scheduler #(
  parameter int SAMPLE_LOG2     = 12,
  parameter int ADDR_W          = 15,
  parameter int STOP_ON_RELEASE = 1,
  parameter int WAIT_TIMEOUT    = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_data,
  output logic              fifo_rd,
  input  logic              pcm_busy,
  output logic              pcm_init,
  output logic              pcm_stop,
  output logic [ADDR_W-1:0] pcm_addr,
  output logic [15:0]       play_count,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, DECODE, STOP, WAIT, START, ARM} state_t;

  state_t            state, state_d;
  logic [7:0]        byte_q, byte_d;
  logic              brk, brk_d;
  logic              ext, ext_d;
  logic              held, held_d;
  logic [2:0]        held_idx, held_idx_d;
  logic [2:0]        play_idx, play_idx_d;
  logic              go_start, go_start_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       count_d;
  logic              err_d;
  logic              key_hit;
  logic [2:0]        key_idx;

  // Strobes come straight from the registered state, so each is one clean cycle wide.
  assign fifo_rd  = (state == IDLE) && !fifo_empty;
  assign pcm_init = (state == START);
  assign pcm_stop = (state == STOP);

  // NOTE: every output of a combinational block gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 3'd0;
    case (byte_q)
      8'h1C:   key_idx = 3'd0;
      8'h1B:   key_idx = 3'd1;
      8'h23:   key_idx = 3'd2;
      8'h2B:   key_idx = 3'd3;
      8'h34:   key_idx = 3'd4;
      8'h33:   key_idx = 3'd5;
      8'h3B:   key_idx = 3'd6;
      8'h42:   key_idx = 3'd7;
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state;
    byte_d     = byte_q;
    brk_d      = brk;
    ext_d      = ext;
    held_d     = held;
    held_idx_d = held_idx;
    play_idx_d = play_idx;
    go_start_d = go_start;
    wait_cnt_d = wait_cnt;
    addr_d     = pcm_addr;
    count_d    = play_count;
    err_d      = err_timeout;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          byte_d  = fifo_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (!key_hit || ext) begin
          // Extended variants of mapped keys are deliberately ignored, as are protocol bytes.
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else if (brk) begin
          brk_d = 1'b0;
          if (held && key_idx == held_idx) held_d = 1'b0;
          if (STOP_ON_RELEASE != 0 && pcm_busy && key_idx == play_idx) begin
            go_start_d = 1'b0;
            state_d    = STOP;
          end
        end else if (!(held && key_idx == held_idx)) begin
          held_d     = 1'b1;
          held_idx_d = key_idx;
          go_start_d = 1'b1;
          state_d    = pcm_busy ? STOP : START;
        end
      end
      STOP: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt + CNT_W'(1);
        if (!pcm_busy || wait_cnt == CNT_LAST) begin
          if (pcm_busy) err_d = 1'b1;
          state_d = go_start ? START : IDLE;
        end
      end
      START:   state_d = ARM;
      ARM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Address is loaded on entry to START so it is already valid while pcm_init is high.
    if (state_d == START) begin
      addr_d     = ADDR_W'(held_idx_d) << SAMPLE_LOG2;
      play_idx_d = held_idx_d;
      count_d    = play_count + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      byte_q      <= '0;
      brk         <= 1'b0;
      ext         <= 1'b0;
      held        <= 1'b0;
      held_idx    <= '0;
      play_idx    <= '0;
      go_start    <= 1'b0;
      wait_cnt    <= '0;
      pcm_addr    <= '0;
      play_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      byte_q      <= byte_d;
      brk         <= brk_d;
      ext         <= ext_d;
      held        <= held_d;
      held_idx    <= held_idx_d;
      play_idx    <= play_idx_d;
      go_start    <= go_start_d;
      wait_cnt    <= wait_cnt_d;
      pcm_addr    <= addr_d;
      play_count  <= count_d;
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_keypress_pcm_scheduler.sv
// Directed bench for keypress_pcm_scheduler: FIFO model, optional player-busy follower,
// hand-written multi-cycle scenarios and a table of single-key vectors.
module tb_keypress_pcm_scheduler;

  localparam int SAMPLE_LOG2 = 12;
  localparam int ADDR_W      = 15;
  localparam int TMO         = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [7:0]        fifo_data;
  logic              fifo_rd;
  logic              pcm_busy;
  logic              pcm_init;
  logic              pcm_stop;
  logic [ADDR_W-1:0] pcm_addr;
  logic [15:0]       play_count;
  logic              err_timeout;

  always #5 clk = ~clk;

  keypress_pcm_scheduler #(
    .SAMPLE_LOG2(SAMPLE_LOG2),
    .ADDR_W(ADDR_W),
    .STOP_ON_RELEASE(1),
    .WAIT_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_rd(fifo_rd),
    .pcm_busy(pcm_busy),
    .pcm_init(pcm_init),
    .pcm_stop(pcm_stop),
    .pcm_addr(pcm_addr),
    .play_count(play_count),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [7:0]        code;
    bit                init;
    logic [ADDR_W-1:0] addr;
  } vec_t;

  vec_t       vecs[17];
  logic [7:0] q[$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, n_pop = 0, n_init = 0, n_stop = 0;
  int pop_cyc = 0, init_cyc = 0, stop_cyc = 0, err_cyc = -1;
  bit rd_pend = 1'b0, overlap = 1'b0, follow = 1'b0;
  int i0, s0, p0, drop, s_at;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  // One clock: sample the pop strobe before the edge, retire the popped byte after it,
  // then observe outputs away from the edge.
  task automatic tick();
    #1;
    rd_pend = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_pend) begin
      if (q.size() != 0) void'(q.pop_front());
      n_pop++;
      pop_cyc = cyc;
    end
    cyc++;
    refresh();
    #1;
    if (pcm_init) begin
      n_init++;
      init_cyc = cyc;
      if (follow) pcm_busy = 1'b1;
    end
    if (pcm_stop) begin
      n_stop++;
      stop_cyc = cyc;
    end
    if (pcm_init && pcm_stop) overlap = 1'b1;
    if (err_timeout && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_stop(input int bound, input string name);
    int base;
    int k;
    base = n_stop;
    k = 0;
    while (n_stop == base && k < bound) begin
      tick();
      k++;
    end
    check(name, longint'(n_stop != base), 1);
  endtask

  task automatic wait_init(input int bound, input string name);
    int base;
    int k;
    base = n_init;
    k = 0;
    while (n_init == base && k < bound) begin
      tick();
      k++;
    end
    check(name, longint'(n_init != base), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " fifo_rd"}, fifo_rd, 0);
    check({tag, " pcm_init"}, pcm_init, 0);
    check({tag, " pcm_stop"}, pcm_stop, 0);
    check({tag, " pcm_addr"}, pcm_addr, 0);
    check({tag, " play_count"}, play_count, 0);
    check({tag, " err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 1'b1, 15'h0000};
    vecs[1]  = '{8'h1B, 1'b1, 15'h1000};
    vecs[2]  = '{8'h23, 1'b1, 15'h2000};
    vecs[3]  = '{8'h2B, 1'b1, 15'h3000};
    vecs[4]  = '{8'h34, 1'b1, 15'h4000};
    vecs[5]  = '{8'h33, 1'b1, 15'h5000};
    vecs[6]  = '{8'h3B, 1'b1, 15'h6000};
    vecs[7]  = '{8'h42, 1'b1, 15'h7000};
    vecs[8]  = '{8'h5A, 1'b0, 15'h7000};
    vecs[9]  = '{8'h42, 1'b0, 15'h7000};
    vecs[10] = '{8'hAA, 1'b0, 15'h7000};
    vecs[11] = '{8'hF0, 1'b0, 15'h7000};
    vecs[12] = '{8'h42, 1'b0, 15'h7000};
    vecs[13] = '{8'h42, 1'b1, 15'h7000};
    vecs[14] = '{8'hE0, 1'b0, 15'h7000};
    vecs[15] = '{8'h42, 1'b0, 15'h7000};
    vecs[16] = '{8'h1C, 1'b1, 15'h0000};

    rst      = 1'b1;
    pcm_busy = 1'b0;
    refresh();
    run(2);
    check_all_zero("reset");
    rst = 1'b0;

    // Idle player, single make code.
    follow = 1'b1;
    p0 = n_pop; i0 = n_init;
    push(8'h1C);
    run(8);
    check("s1 pops", n_pop - p0, 1);
    check("s1 inits", n_init - i0, 1);
    check("s1 init latency", init_cyc - pop_cyc, 2);
    check("s1 addr", pcm_addr, 15'h0000);
    check("s1 count", play_count, 1);

    // Busy player: stop, hold busy 5 cycles, then init one cycle after release.
    s0 = n_stop; i0 = n_init;
    push(8'h1B);
    wait_stop(10, "s2 stop seen");
    check("s2 stop latency", stop_cyc - pop_cyc, 2);
    run(5);
    check("s2 no early init", n_init - i0, 0);
    pcm_busy = 1'b0;
    drop = cyc;
    run(1);
    check("s2 init after drop", init_cyc - drop, 1);
    run(4);
    check("s2 addr", pcm_addr, 15'h1000);
    check("s2 count", play_count, 2);
    check("s2 stops", n_stop - s0, 1);

    // Typematic repeats then release of the playing key.
    pcm_busy = 1'b0;
    run(2);
    s0 = n_stop; i0 = n_init; p0 = n_pop;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    run(30);
    check("s3 inits", n_init - i0, 1);
    check("s3 stops", n_stop - s0, 1);
    check("s3 init before stop", longint'(init_cyc < stop_cyc), 1);
    check("s3 pops", n_pop - p0, 5);
    pcm_busy = 1'b0;
    run(3);
    check("s3 no init after stop", n_init - i0, 1);
    push(8'h1C);
    run(8);
    check("s3 held cleared", n_init - i0, 2);
    check("s3 addr", pcm_addr, 15'h0000);

    // Move off key 0 so an E0-prefixed 1C would be visible if not suppressed.
    pcm_busy = 1'b0;
    run(3);
    push(8'h33);
    run(8);
    check("s4 pre addr", pcm_addr, 15'h5000);
    pcm_busy = 1'b0;
    run(3);
    s0 = n_stop; i0 = n_init; p0 = n_pop;
    push(8'hE0); push(8'h1C); push(8'h00); push(8'h5A);
    run(14);
    check("s4 inits", n_init - i0, 0);
    check("s4 stops", n_stop - s0, 0);
    check("s4 pops", n_pop - p0, 4);
    push(8'h2B);
    run(8);
    check("s4 flags clear init", n_init - i0, 1);
    check("s4 flags clear addr", pcm_addr, 15'h3000);

    // Player stuck busy: timeout path.
    follow   = 1'b0;
    pcm_busy = 1'b1;
    check("s5 err before", err_timeout, 0);
    push(8'h23);
    wait_stop(10, "s5 stop seen");
    s_at = stop_cyc;
    wait_init(TMO + 10, "s5 init seen");
    check("s5 err cycle", err_cyc - s_at, TMO + 1);
    check("s5 init cycle", init_cyc - s_at, TMO + 1);
    check("s5 addr", pcm_addr, 15'h2000);
    run(20);
    check("s5 err sticky", err_timeout, 1);

    // Reset in the middle of WAIT.
    push(8'h1B);
    wait_stop(10, "s6 stop seen");
    run(3);
    i0 = n_init;
    rst = 1'b1;
    tick();
    check_all_zero("s6 after rst");
    rst = 1'b0;
    run(5);
    check("s6 no pulse after rst", n_init - i0, 0);
    pcm_busy = 1'b0;
    push(8'h34);
    run(8);
    check("s6 inits", n_init - i0, 1);
    check("s6 addr", pcm_addr, 15'h4000);
    check("s6 count", play_count, 1);

    // Table of single bytes against an idle player.
    pcm_busy = 1'b0;
    for (int v = 0; v < 17; v++) begin
      s0 = n_stop; i0 = n_init; p0 = n_pop;
      push(vecs[v].code);
      run(6);
      check($sformatf("vec%0d init", v), n_init - i0, longint'(vecs[v].init));
      check($sformatf("vec%0d pops", v), n_pop - p0, 1);
      check($sformatf("vec%0d stops", v), n_stop - s0, 0);
      check($sformatf("vec%0d addr", v), pcm_addr, vecs[v].addr);
    end

    check("init/stop overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
